// File: rtl/spi_pkg.sv
//==============================================================================
// Module   : spi_pkg
// Shared FSM encoding, FIFO depth and SPI mode constants for the SPI master.
// Revision : 1.0
//==============================================================================
`default_nettype none

package spi_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_LEAD  = 3'd1,
      ST_HI    = 3'd2,
      ST_LO    = 3'd3,
      ST_TRAIL = 3'd4,
      ST_GAP   = 3'd5
   } spi_state_e;

   localparam int   FIFO_DEPTH = 8;
   localparam logic CPOL       = 1'b0;
   localparam logic CPHA       = 1'b0;

endpackage

`default_nettype wire

// File: rtl/spi_txfifo.sv
//==============================================================================
// Module   : spi_txfifo
// 8x8 first-word-fall-through FIFO with occupancy count, full and empty.
// Revision : 1.0
//==============================================================================
`default_nettype none

module spi_txfifo
   import spi_pkg::*;
(
   input  logic       clk,
   input  logic       resetn,
   input  logic [7:0] wdata_i,
   input  logic       push_i,
   input  logic       pop_i,
   output logic [7:0] rdata_o,
   output logic [3:0] count_o,
   output logic       full_o,
   output logic       empty_o
);

   logic [7:0] mem_q [FIFO_DEPTH];
   logic [2:0] wptr_q, wptr_d;
   logic [2:0] rptr_q, rptr_d;
   logic [3:0] count_q, count_d;
   logic       w_do_push;
   logic       w_do_pop;

   assign full_o    = (count_q == 4'(FIFO_DEPTH));
   assign empty_o   = (count_q == 4'd0);
   assign count_o   = count_q;
   assign rdata_o   = mem_q[rptr_q];
   // A full FIFO drops the write even if a pop happens in the same cycle.
   assign w_do_push = push_i && !full_o;
   assign w_do_pop  = pop_i && !empty_o;

   always_comb begin
      wptr_d  = w_do_push ? wptr_q + 3'd1 : wptr_q;
      rptr_d  = w_do_pop  ? rptr_q + 3'd1 : rptr_q;
      count_d = count_q;
      case ({w_do_push, w_do_pop})
         2'b10:   count_d = count_q + 4'd1;
         2'b01:   count_d = count_q - 4'd1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (w_do_push) begin
         mem_q[wptr_q] <= wdata_i;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         wptr_q  <= 3'd0;
         rptr_q  <= 3'd0;
         count_q <= 4'd0;
      end else begin
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         count_q <= count_d;
      end
   end

endmodule

`default_nettype wire

// File: rtl/spimaster.sv
//==============================================================================
// Module   : spimaster
// SPI mode-0 master: FIFO-fed MSB-first transmitter with full-duplex receive.
// Revision : 1.0
//==============================================================================
`default_nettype none

module spimaster
   import spi_pkg::*;
#(
   parameter int unsigned CLKDIV = 4
)
(
   input  logic       clk,
   input  logic       resetn,
   input  logic [7:0] wdata,
   input  logic       wstrb,
   output logic       full,
   output logic       busy,
   output logic [7:0] rdata,
   output logic       rvalid,
   output logic       ss,
   output logic       sclk,
   output logic       mosi,
   input  logic       miso
);

   localparam logic [7:0] HCNT_RELOAD = 8'(CLKDIV - 1);

   if (CLKDIV < 1 || CLKDIV > 255) begin : g_bad_clkdiv
      $error("spimaster: CLKDIV must be in 1..255");
   end
   if (CPOL != 1'b0 || CPHA != 1'b0) begin : g_bad_mode
      $error("spimaster: only SPI mode 0 is implemented");
   end

   spi_state_e state_q, state_d;
   logic [7:0] hcnt_q, hcnt_d;
   logic [2:0] bitcnt_q, bitcnt_d;
   logic [7:0] shreg_q, shreg_d;
   logic [7:0] rxsh_q, rxsh_d;
   logic [7:0] rdata_q, rdata_d;
   logic       rvalid_q, rvalid_d;
   logic       ss_q, ss_d;
   logic       sclk_q, sclk_d;
   logic       mosi_q, mosi_d;

   logic       w_pop;
   logic       w_tick;
   logic [7:0] w_fifo_rdata;
   logic [3:0] w_fifo_count;
   logic       w_fifo_full;
   logic       w_fifo_empty;

   spi_txfifo u_txfifo (
      .clk     (clk),
      .resetn  (resetn),
      .wdata_i (wdata),
      .push_i  (wstrb),
      .pop_i   (w_pop),
      .rdata_o (w_fifo_rdata),
      .count_o (w_fifo_count),
      .full_o  (w_fifo_full),
      .empty_o (w_fifo_empty)
   );

   assign w_tick = (hcnt_q == 8'd0);

   always_comb begin
      state_d  = state_q;
      hcnt_d   = (w_tick) ? HCNT_RELOAD : hcnt_q - 8'd1;
      bitcnt_d = bitcnt_q;
      shreg_d  = shreg_q;
      rxsh_d   = rxsh_q;
      rdata_d  = rdata_q;
      rvalid_d = 1'b0;
      ss_d     = ss_q;
      sclk_d   = sclk_q;
      mosi_d   = mosi_q;
      w_pop    = 1'b0;

      case (state_q)
         ST_IDLE: begin
            hcnt_d = HCNT_RELOAD;
            ss_d   = 1'b1;
            sclk_d = CPOL;
            if (!w_fifo_empty) begin
               w_pop    = 1'b1;
               shreg_d  = w_fifo_rdata;
               mosi_d   = w_fifo_rdata[7];
               ss_d     = 1'b0;
               bitcnt_d = 3'd0;
               state_d  = ST_LEAD;
            end
         end
         ST_LEAD, ST_LO: begin
            if (w_tick) begin
               sclk_d  = ~CPOL;
               rxsh_d  = {rxsh_q[6:0], miso};
               state_d = ST_HI;
            end
         end
         ST_HI: begin
            if (w_tick) begin
               sclk_d = CPOL;
               if (bitcnt_q != 3'd7) begin
                  bitcnt_d = bitcnt_q + 3'd1;
                  shreg_d  = {shreg_q[6:0], 1'b0};
                  mosi_d   = shreg_q[6];
                  state_d  = ST_LO;
               end else begin
                  rdata_d  = rxsh_q;
                  rvalid_d = 1'b1;
                  // Back-to-back bytes keep ss low and skip the lead-in.
                  if (!w_fifo_empty) begin
                     w_pop    = 1'b1;
                     shreg_d  = w_fifo_rdata;
                     mosi_d   = w_fifo_rdata[7];
                     bitcnt_d = 3'd0;
                     state_d  = ST_LO;
                  end else begin
                     state_d  = ST_TRAIL;
                  end
               end
            end
         end
         ST_TRAIL: begin
            if (w_tick) begin
               ss_d    = 1'b1;
               mosi_d  = 1'b0;
               state_d = ST_GAP;
            end
         end
         ST_GAP: begin
            if (w_tick) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q  <= ST_IDLE;
         hcnt_q   <= HCNT_RELOAD;
         bitcnt_q <= 3'd0;
         shreg_q  <= 8'd0;
         rxsh_q   <= 8'd0;
         rdata_q  <= 8'd0;
         rvalid_q <= 1'b0;
         ss_q     <= 1'b1;
         sclk_q   <= CPOL;
         mosi_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         hcnt_q   <= hcnt_d;
         bitcnt_q <= bitcnt_d;
         shreg_q  <= shreg_d;
         rxsh_q   <= rxsh_d;
         rdata_q  <= rdata_d;
         rvalid_q <= rvalid_d;
         ss_q     <= ss_d;
         sclk_q   <= sclk_d;
         mosi_q   <= mosi_d;
      end
   end

   assign full   = w_fifo_full;
   assign busy   = (state_q != ST_IDLE) || (w_fifo_count != 4'd0);
   assign rdata  = rdata_q;
   assign rvalid = rvalid_q;
   assign ss     = ss_q;
   assign sclk   = sclk_q;
   assign mosi   = mosi_q;

endmodule

`default_nettype wire

// File: tb/tb_spimaster.sv
//==============================================================================
// Module   : tb_spimaster
// Scoreboard bench for spimaster with a mode-0 slave model and loopback.
// Revision : 1.0
//==============================================================================
`default_nettype none

module tb_spimaster;

   localparam int CLKDIV_A = 2;
   localparam int CLKDIV_B = 1;

   logic       clk = 1'b0;
   logic       resetn = 1'b0;
   always #5 clk = ~clk;

   logic [7:0] wdata;
   logic       wstrb;
   logic       full, busy, rvalid, ss, sclk, mosi, miso;
   logic [7:0] rdata;

   logic [7:0] b_wdata;
   logic       b_wstrb;
   logic       b_full, b_busy, b_rvalid, b_ss, b_sclk, b_mosi;
   logic [7:0] b_rdata;

   logic       loopback = 1'b1;
   logic [7:0] slv_sh = 8'h00;
   int         slv_n = 0;
   logic [7:0] slv_q[$];

   assign miso = loopback ? mosi : slv_sh[7];

   spimaster #(.CLKDIV(CLKDIV_A)) u_dut_a (
      .clk(clk), .resetn(resetn), .wdata(wdata), .wstrb(wstrb),
      .full(full), .busy(busy), .rdata(rdata), .rvalid(rvalid),
      .ss(ss), .sclk(sclk), .mosi(mosi), .miso(miso)
   );

   spimaster #(.CLKDIV(CLKDIV_B)) u_dut_b (
      .clk(clk), .resetn(resetn), .wdata(b_wdata), .wstrb(b_wstrb),
      .full(b_full), .busy(b_busy), .rdata(b_rdata), .rvalid(b_rvalid),
      .ss(b_ss), .sclk(b_sclk), .mosi(b_mosi), .miso(b_mosi)
   );

   int n_cmp = 0;
   int n_fail = 0;
   int cyc = 0;

   always @(posedge clk) begin
      cyc = cyc + 1;
      if (cyc > 60000) begin
         $display("FAIL watchdog: cycle %0d reached, required completion before 60000", cyc);
         $fatal(1);
      end
   end

   function automatic void check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
      end
   endfunction

   // Expected transfer: the byte that must appear on mosi and the byte rdata must return.
   typedef struct packed {
      logic [7:0] tx;
      logic [7:0] rx;
   } exp_t;
   exp_t exp_q[$];

   // Mode-0 slave: first bit valid at ss fall, next bit after every sclk fall.
   always @(negedge ss) begin
      slv_sh = (slv_q.size() != 0) ? slv_q.pop_front() : 8'h00;
      slv_n  = 0;
   end
   always @(negedge sclk) begin
      if (!ss && resetn) begin
         slv_n++;
         if (slv_n == 8) begin
            slv_n  = 0;
            slv_sh = (slv_q.size() != 0) ? slv_q.pop_front() : 8'h00;
         end else begin
            slv_sh = {slv_sh[6:0], 1'b0};
         end
      end
   end

   // Monitor: collects mosi bits at sclk rises and scores each rvalid.
   logic       p_sclk = 1'b0, p_ss = 1'b1, p_mosi = 1'b0;
   logic [7:0] mbits = 8'h00;
   int         nbits = 0, rises = 0, ss_rises = 0, rv_cyc = 0, ssr_cyc = 0;

   always @(negedge clk) begin
      if (!resetn) begin
         nbits  = 0;
         p_sclk = 1'b0;
         p_ss   = 1'b1;
         p_mosi = 1'b0;
      end else begin
         if (mosi !== p_mosi) check("mosi_changes_only_with_sclk_low", sclk, 0);
         if (sclk && !p_sclk) begin
            rises++;
            mbits = {mbits[6:0], mosi};
            nbits++;
            check("ss_low_at_sclk_rise", ss, 0);
         end
         if (ss && !p_ss) begin
            ss_rises++;
            ssr_cyc = cyc;
         end
         if (rvalid) begin
            exp_t e;
            rv_cyc = cyc;
            check("scoreboard_has_entry_at_rvalid", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
               e = exp_q.pop_front();
               check("rdata", rdata, e.rx);
               check("mosi_byte", mbits, e.tx);
               check("sclk_rises_per_byte", nbits, 8);
            end
            nbits = 0;
         end
         p_sclk = sclk;
         p_ss   = ss;
         p_mosi = mosi;
      end
   end

   // Issue one write on the cycle after the next edge and record what it must produce.
   task automatic drive_write(input logic [7:0] tx, input logic [7:0] rx, input bit accepted);
      @(posedge clk);
      #1;
      wdata = tx;
      wstrb = 1'b1;
      if (accepted) begin
         exp_q.push_back('{tx: tx, rx: (loopback ? tx : rx)});
         if (!loopback) slv_q.push_back(rx);
      end
   endtask

   task automatic end_write();
      @(posedge clk);
      #1;
      wstrb = 1'b0;
   endtask

   // After the last byte: ss rises CLKDIV cycles after the final sclk fall, busy after TRAIL+GAP.
   task automatic wait_idle();
      int t;
      t = 0;
      while ((busy || exp_q.size() != 0) && t < 3000) begin
         @(negedge clk);
         t++;
      end
      check("idle_within_budget", t < 3000, 1);
      check("busy_fall_after_gap", cyc - rv_cyc, 2 * CLKDIV_A);
      check("ss_rise_after_last_fall", ssr_cyc - rv_cyc, CLKDIV_A);
   endtask

   initial begin
      int r0, s0, t, mcnt, n;
      logic [7:0] tx, rx;
      int first, last, badper, nr, rvc;
      logic [7:0] bbits, brd;
      logic pb;

      wdata = 8'h00; wstrb = 1'b0;
      b_wdata = 8'h00; b_wstrb = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_ss", ss, 1);
      check("reset_sclk", sclk, 0);
      check("reset_mosi", mosi, 0);
      check("reset_rvalid", rvalid, 0);
      check("reset_rdata", rdata, 0);
      check("reset_full", full, 0);
      check("reset_busy", busy, 0);
      resetn = 1'b1;
      repeat (2) @(posedge clk);

      // Single byte in loopback, with start-up latency.
      loopback = 1'b1;
      r0 = rises; s0 = ss_rises;
      drive_write(8'hA5, 8'h00, 1'b1);
      end_write();
      check("ss_still_high_one_edge_after_write", ss, 1);
      @(posedge clk);
      #1;
      check("ss_low_two_edges_after_write", ss, 0);
      wait_idle();
      check("a5_sclk_rises", rises - r0, 8);
      check("a5_ss_rises", ss_rises - s0, 1);

      // Back-to-back pair keeps ss low across both bytes.
      r0 = rises; s0 = ss_rises;
      drive_write(8'h3C, 8'h00, 1'b1);
      drive_write(8'hC3, 8'h00, 1'b1);
      end_write();
      wait_idle();
      check("pair_sclk_rises", rises - r0, 16);
      check("pair_ss_rises", ss_rises - s0, 1);

      // Ten consecutive writes: the first byte leaves the FIFO on the second cycle,
      // later ones stay queued because a byte lasts far longer than the burst.
      for (int i = 0; i < 10; i++) begin
         mcnt = (i >= 2) ? i - 1 : i;
         drive_write(8'(i), 8'h00, mcnt < 8);
         check("full_during_burst", full, mcnt == 8);
      end
      end_write();
      wait_idle();
      check("full_clear_after_drain", full, 0);

      // Slave returns 0x5A while 0xFF is sent.
      loopback = 1'b0;
      drive_write(8'hFF, 8'h5A, 1'b1);
      end_write();
      wait_idle();

      // Random full-duplex bursts against the slave model.
      for (int b = 0; b < 6; b++) begin
         n = $urandom_range(1, 8);
         for (int k = 0; k < n; k++) begin
            tx = 8'($urandom);
            rx = 8'($urandom);
            drive_write(tx, rx, 1'b1);
         end
         end_write();
         wait_idle();
      end

      // Asynchronous reset mid-byte, with more bytes still queued.
      loopback = 1'b1;
      r0 = rises;
      drive_write(8'h55, 8'h00, 1'b1);
      drive_write(8'h66, 8'h00, 1'b1);
      drive_write(8'h77, 8'h00, 1'b1);
      end_write();
      t = 0;
      while (rises < r0 + 4 && t < 500) begin
         @(negedge clk);
         #1;
         t++;
      end
      check("fourth_rise_within_budget", t < 500, 1);
      resetn = 1'b0;
      #1;
      check("midbyte_reset_ss", ss, 1);
      check("midbyte_reset_sclk", sclk, 0);
      check("midbyte_reset_mosi", mosi, 0);
      check("midbyte_reset_busy", busy, 0);
      check("midbyte_reset_full", full, 0);
      exp_q.delete();
      slv_q.delete();
      repeat (2) @(posedge clk);
      #1;
      resetn = 1'b1;
      repeat (40) @(negedge clk);
      check("no_activity_after_reset_busy", busy, 0);
      check("no_activity_after_reset_ss", ss, 1);
      drive_write(8'h81, 8'h00, 1'b1);
      end_write();
      wait_idle();

      // CLKDIV=1 instance: first rise to rvalid is 15 edges (16 cycles counted inclusively).
      check("b_idle_full", b_full, 0);
      @(posedge clk);
      #1;
      b_wdata = 8'h01;
      b_wstrb = 1'b1;
      @(posedge clk);
      #1;
      b_wstrb = 1'b0;
      first = -1; last = -1; badper = 0; nr = 0; rvc = -1;
      bbits = 8'h00; brd = 8'h00; pb = 1'b0;
      for (int k = 0; k < 300; k++) begin
         @(negedge clk);
         if (b_sclk && !pb) begin
            if (nr > 0 && cyc - last != 2) badper++;
            if (nr == 0) first = cyc;
            last = cyc;
            nr++;
            bbits = {bbits[6:0], b_mosi};
         end
         pb = b_sclk;
         if (b_rvalid) begin
            rvc = cyc;
            brd = b_rdata;
            break;
         end
      end
      check("b_sclk_rises", nr, 8);
      check("b_sclk_period_2", badper, 0);
      check("b_mosi_byte", bbits, 8'h01);
      check("b_rdata", brd, 8'h01);
      check("b_first_rise_to_rvalid", rvc - first, 15);
      repeat (10) @(negedge clk);
      check("b_busy_clear", b_busy, 0);
      check("b_ss_high", b_ss, 1);

      check("scoreboard_drained", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_cmp, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
